// File: rtl/debounce_pkg.sv
// Shared constants for the debounce bank: default timing and channel count.
package debounce_pkg;

  localparam int unsigned DEBOUNCE_DELAY      = 1000000;
  localparam int unsigned DEFAULT_DELAY       = DEBOUNCE_DELAY;
  localparam int unsigned DEFAULT_LONG_DELAY  = 50000000;
  localparam int unsigned DEFAULT_SYNC_STAGES = 2;
  localparam int unsigned DEFAULT_NUM_CH      = 6;

endpackage

// File: rtl/debounce_bank_if.sv
// Raw switch levels in, debounced levels and event pulses out.
interface debounce_bank_if import debounce_pkg::*; #(
  parameter int unsigned NUM_CH = DEFAULT_NUM_CH
);

  logic [NUM_CH-1:0] raw_in;
  logic [NUM_CH-1:0] level_out;
  logic [NUM_CH-1:0] rise_pulse;
  logic [NUM_CH-1:0] fall_pulse;
  logic [NUM_CH-1:0] long_pulse;

  modport master (
    output raw_in,
    input  level_out,
    input  rise_pulse,
    input  fall_pulse,
    input  long_pulse
  );

  modport slave (
    input  raw_in,
    output level_out,
    output rise_pulse,
    output fall_pulse,
    output long_pulse
  );

endinterface

// File: rtl/debounce_ch.sv
// One debounce channel: synchroniser, mismatch counter, hold counter and
// registered rise/fall/long pulses.
module debounce_ch import debounce_pkg::*; #(
  parameter int unsigned DELAY       = DEFAULT_DELAY,
  parameter int unsigned LONG_DELAY  = DEFAULT_LONG_DELAY,
  parameter int unsigned SYNC_STAGES = DEFAULT_SYNC_STAGES,
  parameter logic        RESET_VAL   = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic raw_in,
  output logic level_out,
  output logic rise_pulse,
  output logic fall_pulse,
  output logic long_pulse
);

  localparam int unsigned CntW  = $clog2(DELAY + 1);
  localparam int unsigned HoldW = $clog2(LONG_DELAY + 1);
  localparam logic [CntW-1:0]  CntMax  = CntW'(DELAY - 1);
  localparam logic [HoldW-1:0] HoldMax = HoldW'(LONG_DELAY - 1);
  localparam logic [HoldW-1:0] HoldSat = HoldW'(LONG_DELAY);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [CntW-1:0]        cnt_q;
  logic [HoldW-1:0]       hold_q;
  logic                   level_q, rise_q, fall_q, long_q;
  logic                   s;

  assign s = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_q  <= {SYNC_STAGES{RESET_VAL}};
      level_q <= RESET_VAL;
      cnt_q   <= '0;
      hold_q  <= '0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
      long_q  <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], raw_in};
      rise_q <= 1'b0;
      fall_q <= 1'b0;
      long_q <= 1'b0;
      // Any cycle of agreement restarts the run, so bounces never accumulate.
      if (s != level_q) begin
        if (cnt_q == CntMax) begin
          level_q <= s;
          cnt_q   <= '0;
          rise_q  <= s;
          fall_q  <= ~s;
        end else begin
          cnt_q <= cnt_q + CntW'(1);
        end
      end else begin
        cnt_q <= '0;
      end
      // Hold counter parks at LONG_DELAY so the long pulse fires once per press.
      if (level_q) begin
        if (hold_q != HoldSat) hold_q <= hold_q + HoldW'(1);
        long_q <= (hold_q == HoldMax);
      end else begin
        hold_q <= '0;
      end
    end
  end

  assign level_out  = level_q;
  assign rise_pulse = rise_q;
  assign fall_pulse = fall_q;
  assign long_pulse = long_q;

endmodule

// File: rtl/debounce_bank.sv
// Bank of NUM_CH independent debounce channels behind a single interface.
module debounce_bank import debounce_pkg::*; #(
  parameter int unsigned       NUM_CH      = DEFAULT_NUM_CH,
  parameter int unsigned       DELAY       = DEFAULT_DELAY,
  parameter int unsigned       LONG_DELAY  = DEFAULT_LONG_DELAY,
  parameter int unsigned       SYNC_STAGES = DEFAULT_SYNC_STAGES,
  parameter logic [NUM_CH-1:0] RESET_VAL   = '0
) (
  input logic           clk,
  input logic           reset,
  debounce_bank_if.slave bus
);

  logic [NUM_CH-1:0] level_w, rise_w, fall_w, long_w;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    debounce_ch #(
      .DELAY       (DELAY),
      .LONG_DELAY  (LONG_DELAY),
      .SYNC_STAGES (SYNC_STAGES),
      .RESET_VAL   (RESET_VAL[i])
    ) u_ch (
      .clk        (clk),
      .reset      (reset),
      .raw_in     (bus.raw_in[i]),
      .level_out  (level_w[i]),
      .rise_pulse (rise_w[i]),
      .fall_pulse (fall_w[i]),
      .long_pulse (long_w[i])
    );
  end

  assign bus.level_out  = level_w;
  assign bus.rise_pulse = rise_w;
  assign bus.fall_pulse = fall_w;
  assign bus.long_pulse = long_w;

endmodule

// File: tb/tb_debounce_bank.sv
// Self-checking bench for debounce_bank: directed scenarios plus random stimulus
// against a sample-history reference model.
module tb_debounce_bank;

  localparam int unsigned NCH  = 4;
  localparam int unsigned DLY  = 4;
  localparam int unsigned LDLY = 8;
  localparam int unsigned SYNC = 2;

  logic clk = 1'b0;
  logic reset = 1'b0;

  debounce_bank_if #(.NUM_CH(NCH)) bus ();
  debounce_bank_if #(.NUM_CH(1))   bus1 ();

  debounce_bank #(
    .NUM_CH(NCH), .DELAY(DLY), .LONG_DELAY(LDLY), .SYNC_STAGES(SYNC), .RESET_VAL(4'b0000)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  debounce_bank #(
    .NUM_CH(1), .DELAY(1), .LONG_DELAY(LDLY), .SYNC_STAGES(SYNC), .RESET_VAL(1'b0)
  ) dut1 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus1)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passed = 0;

  // Reference model: a level flips once the last DLY synchronised samples all
  // disagree with it; a sample taken at edge n is seen SYNC edges later.
  logic [NCH-1:0] hist [16];
  int             n;
  int             rise_edge [NCH];
  logic [NCH-1:0] m_level, m_rise, m_fall, m_long;

  task automatic model_reset();
    foreach (hist[i]) hist[i] = '0;
    n = 100;
    m_level = '0;
    m_rise  = '0;
    m_fall  = '0;
    m_long  = '0;
    foreach (rise_edge[i]) rise_edge[i] = -1000;
  endtask

  task automatic model_edge();
    logic [NCH-1:0] nl;
    bit run;
    int idx;
    nl = m_level;
    m_rise = '0;
    m_fall = '0;
    m_long = '0;
    n++;
    hist[n % 16] = bus.raw_in;
    for (int c = 0; c < int'(NCH); c++) begin
      run = 1'b1;
      for (int k = 0; k < int'(DLY); k++) begin
        idx = n - int'(SYNC) - k;
        if (hist[idx % 16][c] == m_level[c]) run = 1'b0;
      end
      if (m_level[c] && n == rise_edge[c] + int'(LDLY)) m_long[c] = 1'b1;
      if (run) begin
        nl[c] = ~m_level[c];
        if (nl[c]) begin
          m_rise[c] = 1'b1;
          rise_edge[c] = n;
        end else begin
          m_fall[c] = 1'b1;
        end
      end
    end
    m_level = nl;
  endtask

  task automatic step();
    @(posedge clk);
    if (!reset) model_reset();
    else model_edge();
    #1;
  endtask

  task automatic test_reset();
    bus.raw_in  = '0;
    bus1.raw_in = '0;
    reset = 1'b0;
    step();
    step();
    checks++;
    if ({bus.level_out, bus.rise_pulse, bus.fall_pulse, bus.long_pulse} !== 16'h0) begin
      $display("FAIL reset_state: got %b want 0",
               {bus.level_out, bus.rise_pulse, bus.fall_pulse, bus.long_pulse});
    end else passed++;
    checks++;
    if ({bus1.level_out, bus1.rise_pulse, bus1.fall_pulse, bus1.long_pulse} !== 4'h0) begin
      $display("FAIL reset_state_d1: got %b want 0",
               {bus1.level_out, bus1.rise_pulse, bus1.fall_pulse, bus1.long_pulse});
    end else passed++;
    reset = 1'b1;
    step();
    checks++;
    if ({bus.rise_pulse, bus.fall_pulse, bus.long_pulse} !== 12'h0) begin
      $display("FAIL reset_release_pulses: got %b want 0",
               {bus.rise_pulse, bus.fall_pulse, bus.long_pulse});
    end else passed++;
  endtask

  task automatic test_clean_rise();
    bus.raw_in = '0;
    for (int i = 0; i < 8; i++) step();
    bus.raw_in[0] = 1'b1;
    for (int e = 0; e < 7; e++) begin
      step();
      checks++;
      if ({bus.level_out, bus.rise_pulse, bus.fall_pulse, bus.long_pulse} !==
          {m_level, m_rise, m_fall, m_long}) begin
        $display("FAIL clean_rise_model e%0d: got %b want %b", e,
                 {bus.level_out, bus.rise_pulse, bus.fall_pulse, bus.long_pulse},
                 {m_level, m_rise, m_fall, m_long});
      end else passed++;
      checks++;
      if ({bus.level_out[0], bus.rise_pulse[0]} !== {1'(e >= 5), 1'(e == 5)}) begin
        $display("FAIL clean_rise_timing e%0d: got %b want %b", e,
                 {bus.level_out[0], bus.rise_pulse[0]}, {1'(e >= 5), 1'(e == 5)});
      end else passed++;
    end
  endtask

  task automatic test_bounce();
    int rises_bounce;
    int rises_after;
    int rise_at;
    rises_bounce = 0;
    rises_after  = 0;
    rise_at      = -1;
    for (int seg = 0; seg < 4; seg++) begin
      bus.raw_in[1] = (seg % 2 == 0);
      for (int i = 0; i < 3; i++) begin
        step();
        if (bus.rise_pulse[1]) rises_bounce++;
        checks++;
        if ({bus.level_out, bus.rise_pulse, bus.fall_pulse, bus.long_pulse} !==
            {m_level, m_rise, m_fall, m_long}) begin
          $display("FAIL bounce_model: got %b want %b",
                   {bus.level_out, bus.rise_pulse, bus.fall_pulse, bus.long_pulse},
                   {m_level, m_rise, m_fall, m_long});
        end else passed++;
      end
    end
    bus.raw_in[1] = 1'b1;
    for (int e = 0; e < 10; e++) begin
      step();
      if (bus.rise_pulse[1]) begin
        rises_after++;
        rise_at = e;
      end
    end
    checks++;
    if (rises_bounce !== 0) $display("FAIL bounce_reject: got %0d rises want 0", rises_bounce);
    else passed++;
    checks++;
    if (rises_after !== 1) $display("FAIL bounce_single_rise: got %0d want 1", rises_after);
    else passed++;
    checks++;
    if (rise_at !== int'(DLY + SYNC) - 1)
      $display("FAIL bounce_latency: got edge %0d want %0d", rise_at, DLY + SYNC - 1);
    else passed++;
  endtask

  task automatic test_simultaneous();
    int             nrise;
    logic [NCH-1:0] rise_val;
    logic [NCH-1:0] fall_or;
    nrise = 0;
    rise_val = '0;
    fall_or = '0;
    bus.raw_in = '0;
    for (int i = 0; i < 10; i++) step();
    bus.raw_in = 4'b1010;
    for (int e = 0; e < 10; e++) begin
      step();
      fall_or |= bus.fall_pulse;
      if (bus.rise_pulse != '0) begin
        nrise++;
        rise_val = bus.rise_pulse;
      end
    end
    checks++;
    if (nrise !== 1) $display("FAIL simul_count: got %0d want 1", nrise);
    else passed++;
    checks++;
    if (rise_val !== 4'b1010) $display("FAIL simul_rise: got %b want 1010", rise_val);
    else passed++;
    checks++;
    if (fall_or !== 4'b0000) $display("FAIL simul_fall: got %b want 0000", fall_or);
    else passed++;
  endtask

  task automatic test_long_press();
    int rise_e, long_e, nlong, nfall, long_late;
    rise_e = -1;
    long_e = -1;
    nlong = 0;
    nfall = 0;
    long_late = 0;
    bus.raw_in = '0;
    for (int i = 0; i < 14; i++) step();
    bus.raw_in[2] = 1'b1;
    for (int e = 0; e < 45; e++) begin
      if (e == 20) bus.raw_in[2] = 1'b0;
      step();
      if (bus.rise_pulse[2]) rise_e = e;
      if (bus.long_pulse[2]) begin
        nlong++;
        long_e = e;
        if (nfall > 0) long_late++;
      end
      if (bus.fall_pulse[2]) nfall++;
      checks++;
      if ({bus.level_out, bus.rise_pulse, bus.fall_pulse, bus.long_pulse} !==
          {m_level, m_rise, m_fall, m_long}) begin
        $display("FAIL long_model e%0d: got %b want %b", e,
                 {bus.level_out, bus.rise_pulse, bus.fall_pulse, bus.long_pulse},
                 {m_level, m_rise, m_fall, m_long});
      end else passed++;
    end
    checks++;
    if (nlong !== 1) $display("FAIL long_count: got %0d want 1", nlong);
    else passed++;
    checks++;
    if (long_e - rise_e !== int'(LDLY))
      $display("FAIL long_delay: got %0d want %0d", long_e - rise_e, LDLY);
    else passed++;
    checks++;
    if (nfall !== 1 || long_late !== 0)
      $display("FAIL long_release: got falls %0d late_long %0d want 1 0", nfall, long_late);
    else passed++;
  endtask

  task automatic test_reset_mid_count();
    bus.raw_in = '0;
    for (int i = 0; i < 12; i++) step();
    bus.raw_in[0] = 1'b1;
    for (int i = 0; i < 4; i++) step();
    reset = 1'b0;
    model_reset();
    #1;
    checks++;
    if ({bus.level_out, bus.rise_pulse, bus.fall_pulse, bus.long_pulse} !== 16'h0) begin
      $display("FAIL reset_mid_async: got %b want 0",
               {bus.level_out, bus.rise_pulse, bus.fall_pulse, bus.long_pulse});
    end else passed++;
    step();
    step();
    reset = 1'b1;
    for (int e = 0; e < 7; e++) begin
      step();
      checks++;
      if ({bus.level_out[0], bus.rise_pulse[0]} !== {1'(e >= 5), 1'(e == 5)}) begin
        $display("FAIL reset_mid_latency e%0d: got %b want %b", e,
                 {bus.level_out[0], bus.rise_pulse[0]}, {1'(e >= 5), 1'(e == 5)});
      end else passed++;
    end
  endtask

  task automatic test_delay_one();
    logic [2:0] want [5];
    want[0] = 3'b000;
    want[1] = 3'b000;
    want[2] = 3'b110;
    want[3] = 3'b001;
    want[4] = 3'b000;
    bus1.raw_in = 1'b0;
    for (int i = 0; i < 4; i++) step();
    bus1.raw_in = 1'b1;
    for (int e = 0; e < 5; e++) begin
      step();
      if (e == 0) bus1.raw_in = 1'b0;
      checks++;
      if ({bus1.level_out, bus1.rise_pulse, bus1.fall_pulse} !== want[e]) begin
        $display("FAIL delay_one e%0d: got %b want %b", e,
                 {bus1.level_out, bus1.rise_pulse, bus1.fall_pulse}, want[e]);
      end else passed++;
    end
  endtask

  task automatic test_random();
    for (int cyc = 0; cyc < 600; cyc++) begin
      for (int c = 0; c < int'(NCH); c++) begin
        if ($urandom_range(7) == 0) bus.raw_in[c] = ~bus.raw_in[c];
      end
      if (cyc == 300) begin
        reset = 1'b0;
        model_reset();
      end
      if (cyc == 303) reset = 1'b1;
      step();
      checks++;
      if ({bus.level_out, bus.rise_pulse, bus.fall_pulse, bus.long_pulse} !==
          {m_level, m_rise, m_fall, m_long}) begin
        $display("FAIL random c%0d: got %b want %b", cyc,
                 {bus.level_out, bus.rise_pulse, bus.fall_pulse, bus.long_pulse},
                 {m_level, m_rise, m_fall, m_long});
      end else passed++;
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_clean_rise();
    test_bounce();
    test_simultaneous();
    test_long_press();
    test_reset_mid_count();
    test_delay_one();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/debounce_bank.md
DEBOUNCE_BANK -- requirements
Module: debounce_bank

Interface
REQ-001 SHALL have parameter NUM_CH, default 6, number of independent input channels (1..32).
REQ-002 SHALL have parameter DELAY, default 1000000, number of consecutive mismatching cycles required before an output changes (>=1).
REQ-003 SHALL have parameter LONG_DELAY, default 50000000, number of cycles the debounced level must stay high to flag a long press (>=1).
REQ-004 SHALL have parameter SYNC_STAGES, default 2, depth of the input synchroniser (>=2).
REQ-005 SHALL have parameter RESET_VAL, default all-zeros, NUM_CH-bit value loaded into the synchroniser and level outputs on reset.
REQ-006 SHALL have port clk, input, width 1, single system clock.
REQ-007 SHALL have port reset, input, width 1, with reset asynchronous and active-low.
REQ-008 SHALL have port raw_in, input, width NUM_CH, asynchronous switch and button levels.
REQ-009 SHALL have port level_out, output, width NUM_CH, debounced levels.
REQ-010 SHALL have port rise_pulse, output, width NUM_CH, one-cycle pulse on each debounced 0->1 transition.
REQ-011 SHALL have port fall_pulse, output, width NUM_CH, one-cycle pulse on each debounced 1->0 transition.
REQ-012 SHALL have port long_pulse, output, width NUM_CH, one-cycle pulse when a high level has been held for LONG_DELAY cycles.

Function
REQ-013 SHALL pass each raw_in bit through a SYNC_STAGES-deep flop chain; the last stage is the channel's sampled value s.
REQ-014 SHALL keep, per channel, a mismatch counter of width clog2(DELAY+1) that clears on every cycle where s equals level_out and increments on every cycle where s differs from level_out.
REQ-015 SHALL, on the edge where s differs from level_out and the counter equals DELAY-1, load level_out with s and clear the counter.
REQ-016 SHALL therefore update level_out on the (SYNC_STAGES+DELAY)-th rising edge, counting from the first edge that samples a clean new raw level.
REQ-017 SHALL, on a single cycle of agreement during counting (bounce), clear the counter so that a full DELAY run restarts.
REQ-018 SHALL assert rise_pulse or fall_pulse for exactly one cycle, in the same cycle level_out first shows its new value; the other pulse remains 0.
REQ-019 SHALL keep, per channel, a hold counter of width clog2(LONG_DELAY+1) that counts while level_out is 1, saturates after firing, and clears when level_out is 0.
REQ-020 SHALL assert long_pulse for one cycle, at most once per high period, on the edge where the hold counter reaches LONG_DELAY-1.
REQ-021 SHALL process channels fully independently, so that simultaneous transitions on any subset of channels each produce their own pulses in the same cycle.
REQ-022 SHALL, with DELAY=1, update level_out on the first mismatching cycle, and the mismatch counter SHALL never exceed DELAY-1.

Reset
REQ-023 SHALL, while reset is low, immediately set the synchroniser flops and level_out to RESET_VAL, clear all counters, and drive rise_pulse, fall_pulse and long_pulse to 0.
REQ-024 SHALL generate no rise, fall or long pulse in the first cycle after reset release when raw_in equals RESET_VAL.
REQ-025 SHALL abandon any in-progress count when reset is asserted mid-count, and the count SHALL restart from 0 after release.

Structure
REQ-026 SHALL place the default DELAY, LONG_DELAY and SYNC_STAGES constants in shared package debounce_pkg, alongside the existing DEBOUNCE_DELAY.
REQ-027 SHALL implement per-channel logic in sub-module debounce_ch, comprising the synchroniser, the mismatch counter, the hold counter and the three pulse outputs.
REQ-028 SHALL instantiate debounce_ch NUM_CH times in debounce_bank through a generate loop.

Verification
REQ-029 SHALL verify a clean rise (NUM_CH=4, DELAY=4, SYNC_STAGES=2): raw_in[0] goes 0->1 before edge 0 -> level_out[0] becomes 1 after edge 5 and rise_pulse[0] is high for exactly that one cycle.
REQ-030 SHALL verify bounce rejection: raw_in[1] toggles 1,0,1,0 every 3 cycles, then holds 1 -> no pulse appears until DELAY+SYNC_STAGES cycles after the final change, and exactly one rise_pulse follows.
REQ-031 SHALL verify simultaneous events: raw_in goes 4'b0000->4'b1010 -> rise_pulse equals 4'b1010 for one cycle, and fall_pulse stays 0.
REQ-032 SHALL verify long press (LONG_DELAY=8): channel 2 is held high for 20 cycles -> exactly one long_pulse[2] occurs, 8 cycles after level_out[2] rose; release -> one fall_pulse[2] and no further long_pulse.
REQ-033 SHALL verify reset mid-count: reset goes low at mismatch count 2 and is released -> all outputs equal RESET_VAL with pulses 0, and the full DELAY latency is then required again.
REQ-034 SHALL verify DELAY=1: a single-cycle clean change -> level_out updates SYNC_STAGES+1 edges later.
